// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS writeback path.
package mips_pkg;

    localparam int unsigned DEFAULT_DW = 32;
    localparam int unsigned DEFAULT_AW = 5;

    localparam logic [DEFAULT_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [DEFAULT_AW-1:0] rd;
        logic [DEFAULT_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/mips_writeback_queue_fifo.sv
// Circular buffer with up to two pushes and one implicit pop per cycle.
module wb_dual_push_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 37
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push0_en,
    input  logic [W-1:0]                  push0_data,
    input  logic                          push1_en,
    input  logic [W-1:0]                  push1_data,
    output logic [$clog2(DEPTH)-1:0]      head_ptr,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [DEPTH-1:0][W-1:0]       mem
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [PW-1:0]          head_q;
    logic [PW-1:0]          tail_q;
    logic [CW-1:0]          count_q;
    logic [DEPTH-1:0][W-1:0] mem_q;
    logic                   pop;

    // The head entry is always presented downstream, so any occupied queue pops.
    assign pop = (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(pop);
            tail_q  <= tail_q + PW'(push0_en) + PW'(push1_en);
            count_q <= count_q + CW'(push0_en) + CW'(push1_en) - CW'(pop);
        end
    end

    // push1 is only used together with push0, so it always lands at tail+1.
    always_ff @(posedge clk) begin
        if (push0_en) mem_q[tail_q] <= push0_data;
        if (push1_en) mem_q[tail_q + PW'(1)] <= push1_data;
    end

    assign head_ptr = head_q;
    assign count    = count_q;
    assign mem      = mem_q;

endmodule

// File: rtl/mips_writeback_queue.sv
// Serialises ALU and load results onto the register file write port and
// forwards still-pending results to decode.
module mips_writeback_queue
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = DEFAULT_DW,
    parameter int unsigned AW    = DEFAULT_AW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    input  logic [AW-1:0]                 alu_rd,
    input  logic [DW-1:0]                 alu_data,
    input  logic                          ld_valid,
    input  logic [AW-1:0]                 ld_rd,
    input  logic [DW-1:0]                 ld_data,
    output logic                          in_ready,
    output logic                          rf_write_en,
    output logic [AW-1:0]                 rf_write_addr,
    output logic [DW-1:0]                 rf_write_data,
    input  logic [AW-1:0]                 fwd_addr1,
    input  logic [AW-1:0]                 fwd_addr2,
    output logic                          fwd_hit1,
    output logic                          fwd_hit2,
    output logic [DW-1:0]                 fwd_data1,
    output logic [DW-1:0]                 fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0]    pending,
    output logic                          empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned EW = AW + DW;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    logic                      ld_take;
    logic                      alu_take;
    logic                      push0_en;
    logic                      push1_en;
    entry_t                    push0_entry;
    entry_t                    push1_entry;
    logic [PW-1:0]             head_ptr;
    logic [CW-1:0]             count;
    logic [DEPTH-1:0][EW-1:0]  mem;
    entry_t                    head_entry;

    assign in_ready = (count <= CW'(DEPTH - 2));

    assign ld_take  = ld_valid  && (ld_rd  != AW'(REG_ZERO)) && in_ready;
    assign alu_take = alu_valid && (alu_rd != AW'(REG_ZERO)) && in_ready;

    // Compact the qualifying inputs onto push0/push1; the load is the older
    // instruction, so it takes push0 whenever it qualifies.
    always_comb begin
        push0_en    = ld_take || alu_take;
        push1_en    = ld_take && alu_take;
        push0_entry = ld_take ? entry_t'{ld_rd, ld_data} : entry_t'{alu_rd, alu_data};
        push1_entry = entry_t'{alu_rd, alu_data};
    end

    wb_dual_push_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push0_en   (push0_en),
        .push0_data (push0_entry),
        .push1_en   (push1_en),
        .push1_data (push1_entry),
        .head_ptr   (head_ptr),
        .count      (count),
        .mem        (mem)
    );

    assign head_entry    = entry_t'(mem[head_ptr]);
    assign rf_write_en   = (count != '0);
    assign rf_write_addr = rf_write_en ? head_entry.rd   : '0;
    assign rf_write_data = rf_write_en ? head_entry.data : '0;
    assign pending       = count;
    assign empty         = (count == '0);

    // Walk occupied slots oldest to youngest so the last match wins.
    always_comb begin
        logic [PW-1:0] idx;
        entry_t        slot;
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        idx       = '0;
        slot      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx  = head_ptr + PW'(k);
            slot = entry_t'(mem[idx]);
            if (CW'(k) < count) begin
                if (fwd_addr1 != AW'(REG_ZERO) && slot.rd == fwd_addr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = slot.data;
                end
                if (fwd_addr2 != AW'(REG_ZERO) && slot.rd == fwd_addr2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = slot.data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_writeback_queue.sv
// Scoreboard bench for mips_writeback_queue: queue of expected register writes.
module tb_mips_writeback_queue;
    import mips_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, ld_valid;
    logic [AW-1:0] alu_rd, ld_rd;
    logic [DW-1:0] alu_data, ld_data;
    logic          in_ready;
    logic          rf_write_en;
    logic [AW-1:0] rf_write_addr;
    logic [DW-1:0] rf_write_data;
    logic [AW-1:0] fwd_addr1, fwd_addr2;
    logic          fwd_hit1, fwd_hit2;
    logic [DW-1:0] fwd_data1, fwd_data2;
    logic [CW-1:0] pending;
    logic          empty;

    wb_entry_t exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    mips_writeback_queue #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .in_ready      (in_ready),
        .rf_write_en   (rf_write_en),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .fwd_addr1     (fwd_addr1),
        .fwd_addr2     (fwd_addr2),
        .fwd_hit1      (fwd_hit1),
        .fwd_hit2      (fwd_hit2),
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2),
        .pending       (pending),
        .empty         (empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Youngest pending value for a register, searched from the tail.
    task automatic model_fwd(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != '0) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].rd == a) begin
                    hit = 1'b1;
                    d   = exp_q[i].data;
                    break;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic          h;
        logic [DW-1:0] d;
        int            sz;
        sz = exp_q.size();
        check("rf_write_en", 32'(rf_write_en), 32'(sz > 0));
        check("rf_write_addr", 32'(rf_write_addr), (sz > 0) ? 32'(exp_q[0].rd) : 32'd0);
        check("rf_write_data", rf_write_data, (sz > 0) ? exp_q[0].data : 32'd0);
        check("in_ready", 32'(in_ready), 32'(sz <= int'(DEPTH) - 2));
        check("pending", 32'(pending), 32'(sz));
        check("empty", 32'(empty), 32'(sz == 0));
        model_fwd(fwd_addr1, h, d);
        check("fwd_hit1", 32'(fwd_hit1), 32'(h));
        check("fwd_data1", fwd_data1, d);
        model_fwd(fwd_addr2, h, d);
        check("fwd_hit2", 32'(fwd_hit2), 32'(h));
        check("fwd_data2", fwd_data2, d);
    endtask

    // One cycle: drive at negedge, check, then update model at the posedge.
    task automatic cycle(input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldat,
                         input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                         input logic [AW-1:0] f1, input logic [AW-1:0] f2);
        int sz;
        bit rdy;
        ld_valid  = lv;  ld_rd  = lrd; ld_data  = ldat;
        alu_valid = av;  alu_rd = ard; alu_data = adat;
        fwd_addr1 = f1;  fwd_addr2 = f2;
        #1;
        check_outputs();
        @(posedge clk);
        sz  = exp_q.size();
        rdy = (sz <= int'(DEPTH) - 2);
        if (sz > 0) void'(exp_q.pop_front());
        if (rdy && lv && lrd != '0) exp_q.push_back('{rd: lrd, data: ldat});
        if (rdy && av && ard != '0) exp_q.push_back('{rd: ard, data: adat});
        @(negedge clk);
    endtask

    task automatic idle(input logic [AW-1:0] f1, input logic [AW-1:0] f2);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, f1, f2);
    endtask

    initial begin
        rst_n = 1'b0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        fwd_addr1 = '0; fwd_addr2 = '0;
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // idle sweep over every address
        for (int i = 0; i < 32; i++) idle(AW'(i), AW'(31 - i));

        // single ALU result: visible and forwarded for exactly one cycle
        cycle(1'b0, '0, '0, 1'b1, 5'd5, 32'h1234, 5'd5, 5'd0);
        idle(5'd5, 5'd0);
        idle(5'd5, 5'd5);

        // same-edge load and ALU to r3
        cycle(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB, 5'd3, 5'd3);
        idle(5'd3, 5'd0);
        idle(5'd3, 5'd3);
        idle(5'd3, 5'd3);

        // writes to r0 are dropped
        cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
        cycle(1'b1, 5'd0, 32'h7777, 1'b0, '0, '0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // sustained dual pushes, then a push while in_ready is low
        cycle(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102, 5'd1, 5'd2);
        cycle(1'b1, 5'd4, 32'h104, 1'b1, 5'd6, 32'h106, 5'd2, 5'd4);
        cycle(1'b1, 5'd7, 32'h107, 1'b1, 5'd8, 32'h108, 5'd6, 5'd7);
        cycle(1'b1, 5'd9, 32'h109, 1'b1, 5'd10, 32'h10A, 5'd9, 5'd8);
        for (int i = 0; i < 8; i++) idle(AW'(i + 4), AW'(i + 6));

        // reset with three entries pending
        cycle(1'b1, 5'd11, 32'h211, 1'b1, 5'd12, 32'h212, 5'd11, 5'd12);
        cycle(1'b1, 5'd13, 32'h213, 1'b1, 5'd14, 32'h214, 5'd13, 5'd14);
        ld_valid = 1'b0; alu_valid = 1'b0;
        fwd_addr1 = 5'd13; fwd_addr2 = 5'd14;
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idle(AW'(11 + i), AW'(14 - i));

        // random traffic with collisions, r0 targets and blocked pushes
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 6; i++) idle(AW'(i), AW'(i + 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
